// File: rtl/bist_pkg.sv
// Shared BIST definitions: scan FSM encodings and mode constants.
package bist_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StScan = 2'd1,
    StDone = 2'd2
  } state_e;

  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

endpackage

// File: rtl/mux_scan_ctr.sv
// Dwell and channel counters for the scan sequencer.
module mux_scan_ctr #(
  parameter int unsigned NCH   = 8,
  parameter int unsigned SELW  = $clog2(NCH),
  parameter int unsigned DWELL = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clear,
  input  logic            enable,
  output logic [SELW-1:0] ch_cnt,
  output logic            last_dw,
  output logic            last_ch
);

  localparam int unsigned DWW = $clog2(DWELL + 1);

  logic [DWW-1:0]  dw_cnt_q;
  logic [SELW-1:0] ch_cnt_q;

  assign last_dw = (dw_cnt_q == DWW'(DWELL - 1));
  assign last_ch = (ch_cnt_q == SELW'(NCH - 1));
  assign ch_cnt  = ch_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dw_cnt_q <= '0;
      ch_cnt_q <= '0;
    end else if (clear) begin
      dw_cnt_q <= '0;
      ch_cnt_q <= '0;
    end else if (enable) begin
      if (last_dw) begin
        dw_cnt_q <= '0;
        // Wrap keeps ch_cnt inside 0..NCH-1 even for non-power-of-two NCH.
        ch_cnt_q <= last_ch ? '0 : ch_cnt_q + SELW'(1);
      end else begin
        dw_cnt_q <= dw_cnt_q + DWW'(1);
      end
    end
  end

endmodule

// File: rtl/mux_scan_sel.sv
// Registered N-channel bus selector with manual select and an automatic channel scan.
module mux_scan_sel
  import bist_pkg::*;
#(
  parameter int unsigned WIDTH = 6,
  parameter int unsigned NCH   = 8,
  parameter int unsigned SELW  = $clog2(NCH),
  parameter int unsigned DWELL = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NCH*WIDTH-1:0] din,
  input  logic [SELW-1:0]      sel,
  input  logic                 mode,
  input  logic                 start,
  output logic [WIDTH-1:0]     dout,
  output logic [SELW-1:0]      dout_ch,
  output logic                 dout_vld,
  output logic                 busy,
  output logic                 done
);

  localparam logic [SELW:0] NchExt = (SELW + 1)'(NCH);

  state_e           state_q;
  logic [WIDTH-1:0] dout_q;
  logic [SELW-1:0]  dout_ch_q;
  logic             dout_vld_q, busy_q, done_q;

  logic [WIDTH-1:0] ch_data [NCH];
  logic [SELW-1:0]  man_idx;
  logic [SELW-1:0]  ch_cnt;
  logic             last_dw, last_ch;
  logic             ctr_clear;

  for (genvar k = 0; k < NCH; k++) begin : g_unpack
    assign ch_data[k] = din[k*WIDTH +: WIDTH];
  end

  // Out-of-range selects fall back to channel 0.
  assign man_idx   = ({1'b0, sel} < NchExt) ? sel : '0;
  assign ctr_clear = (state_q != StScan) || (mode == MODE_MANUAL);

  mux_scan_ctr #(
    .NCH   (NCH),
    .SELW  (SELW),
    .DWELL (DWELL)
  ) u_ctr (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (ctr_clear),
    .enable  (!ctr_clear),
    .ch_cnt  (ch_cnt),
    .last_dw (last_dw),
    .last_ch (last_ch)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      dout_q     <= '0;
      dout_ch_q  <= '0;
      dout_vld_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (mode == MODE_MANUAL) begin
            dout_q     <= ch_data[man_idx];
            dout_ch_q  <= man_idx;
            dout_vld_q <= 1'b1;
          end else begin
            dout_vld_q <= 1'b0;
            if (start) begin
              state_q <= StScan;
              busy_q  <= 1'b1;
            end
          end
        end
        StScan: begin
          if (mode == MODE_MANUAL) begin
            state_q    <= StIdle;
            busy_q     <= 1'b0;
            dout_vld_q <= 1'b0;
          end else begin
            dout_q     <= ch_data[ch_cnt];
            dout_ch_q  <= ch_cnt;
            dout_vld_q <= last_dw;
            if (last_dw && last_ch) begin
              state_q <= StDone;
              busy_q  <= 1'b0;
            end
          end
        end
        StDone: begin
          // start is ignored here; a new scan needs one IDLE cycle first.
          done_q     <= 1'b1;
          busy_q     <= 1'b0;
          dout_vld_q <= 1'b0;
          state_q    <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign dout     = dout_q;
  assign dout_ch  = dout_ch_q;
  assign dout_vld = dout_vld_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule
